// File: rtl/instr_decode_queue_pkg.sv
// Shared types and field positions for the Frost32 decode queue.
// Decoded records are built once on entry and carried with their PC tag.
package instr_decode_queue_pkg;

  localparam int NUM_LEGAL_GROUPS = 4;
  localparam int PKG_PC_WIDTH     = 32;

  localparam int GRP_HI  = 31;
  localparam int GRP_LO  = 28;
  localparam int RA_HI   = 27;
  localparam int RA_LO   = 24;
  localparam int RB_HI   = 23;
  localparam int RB_LO   = 20;
  localparam int RC_HI   = 19;
  localparam int RC_LO   = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int IMM0_HI = 11;
  localparam int IMM1_HI = 15;

  typedef struct packed {
    logic [3:0]  group;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  opcode;
    logic [15:0] imm_val;
  } PortOut_InstrDecoder;

  typedef struct packed {
    PortOut_InstrDecoder        dec;
    logic                       invalid;
    logic [PKG_PC_WIDTH-1:0]    pc;
  } DecodedEntry;

endpackage

// File: rtl/instr_decode_queue_field_extract.sv
// Combinational Frost32 field extraction into a DecodedEntry.
// Out-of-range groups are flagged and decoded with the group-0 layout, no immediate.
module instr_field_extract
  import instr_decode_queue_pkg::*;
#(
  parameter int NUM_GROUPS = NUM_LEGAL_GROUPS
) (
  input  logic [31:0]             i_instr,
  input  logic [PKG_PC_WIDTH-1:0] i_pc,
  output DecodedEntry             o_entry
);

  logic [3:0] w_grp;
  assign w_grp = i_instr[GRP_HI:GRP_LO];

  always_comb begin
    o_entry        = '0;
    o_entry.pc     = i_pc;
    o_entry.dec.ra = i_instr[RA_HI:RA_LO];
    o_entry.dec.rb = i_instr[RB_HI:RB_LO];
    if (int'(w_grp) >= NUM_GROUPS) begin
      o_entry.invalid    = 1'b1;
      o_entry.dec.rc     = i_instr[RC_HI:RC_LO];
      o_entry.dec.opcode = i_instr[OPC_HI:OPC_LO];
    end else begin
      o_entry.dec.group = w_grp;
      case (w_grp)
        4'd0: begin
          o_entry.dec.rc      = i_instr[RC_HI:RC_LO];
          o_entry.dec.opcode  = i_instr[OPC_HI:OPC_LO];
          o_entry.dec.imm_val = {4'b0, i_instr[IMM0_HI:0]};
        end
        // Group 1 trades rc for a wide immediate, so opcode moves up a nibble.
        4'd1: begin
          o_entry.dec.opcode  = i_instr[RC_HI:RC_LO];
          o_entry.dec.imm_val = i_instr[IMM1_HI:0];
        end
        default: begin
          o_entry.dec.rc     = i_instr[RC_HI:RC_LO];
          o_entry.dec.opcode = i_instr[OPC_HI:OPC_LO];
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode-on-entry instruction FIFO between fetch and execute.
// No in->out bypass; flush and reset clear pointers and count.
module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 4,
  parameter int NUM_GROUPS  = NUM_LEGAL_GROUPS,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [INSTR_WIDTH-1:0] i_in_instr,
  input  logic [PC_WIDTH-1:0]    i_in_pc,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output PortOut_InstrDecoder    o_out_decoded,
  output logic                   o_out_invalid,
  output logic [PC_WIDTH-1:0]    o_out_pc,
  output logic [CNT_W-1:0]       o_count
);

  generate
    if (INSTR_WIDTH != 32) begin : g_bad_iw
      $error("instr_decode_queue: INSTR_WIDTH must be 32");
    end
    if (PC_WIDTH > PKG_PC_WIDTH) begin : g_bad_pw
      $error("instr_decode_queue: PC_WIDTH exceeds stored PC width");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_decode_queue: DEPTH must be a power of two >= 2");
    end
  endgenerate

  DecodedEntry             r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;
  DecodedEntry             w_entry;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;

  instr_field_extract #(.NUM_GROUPS(NUM_GROUPS)) u_extract (
    .i_instr (i_in_instr[31:0]),
    .i_pc    (PKG_PC_WIDTH'(i_in_pc)),
    .o_entry (w_entry)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_in_valid && !w_full;
  assign w_pop   = !w_empty && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      // Clear stale invalid flags so the idle read slot never reports invalid.
      for (int i = 0; i < DEPTH; i++) r_mem[i].invalid <= 1'b0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_in_ready    = !w_full;
  assign o_out_valid   = !w_empty;
  assign o_out_decoded = r_mem[r_rptr].dec;
  assign o_out_invalid = r_mem[r_rptr].invalid;
  assign o_out_pc      = r_mem[r_rptr].pc[PC_WIDTH-1:0];
  assign o_count       = r_count;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: expected records queued on push,
// compared field by field on pop; occupancy and handshakes checked each cycle.
module tb_instr_decode_queue;
  import instr_decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [3:0]  g, ra, rb, rc, op;
    logic [15:0] imm;
    logic        inv;
    logic [31:0] pc;
  } exp_t;

  logic                gclk = 1'b0;
  logic                reset, flush, in_valid, out_ready;
  logic [31:0]         in_instr, in_pc;
  logic                in_ready, out_valid, out_invalid;
  PortOut_InstrDecoder out_dec;
  logic [31:0]         out_pc;
  logic [CNT_W-1:0]    count;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 gclk = ~gclk;

  instr_decode_queue #(.INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH), .NUM_GROUPS(4)) dut (
    .i_clk         (gclk),
    .i_reset       (reset),
    .i_flush       (flush),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_instr    (in_instr),
    .i_in_pc       (in_pc),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_decoded (out_dec),
    .o_out_invalid (out_invalid),
    .o_out_pc      (out_pc),
    .o_count       (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.g = w[31:28]; e.ra = w[27:24]; e.rb = w[23:20];
    e.rc = w[19:16]; e.op = w[15:12]; e.imm = 16'h0; e.inv = 1'b0; e.pc = pc;
    if (w[31:28] >= 4'd4) begin
      e.inv = 1'b1; e.g = 4'd0;
    end else if (w[31:28] == 4'd0) begin
      e.imm = {4'h0, w[11:0]};
    end else if (w[31:28] == 4'd1) begin
      e.rc = 4'd0; e.op = w[19:16]; e.imm = w[15:0];
    end
    return e;
  endfunction

  // One clock: drive at negedge, check just after, advance the model at posedge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl = 1'b0, input logic rs = 1'b0);
    logic do_push, do_pop;
    exp_t h;
    @(negedge gclk);
    in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl; reset = rs;
    #1;
    chk("count", 64'(count), 64'(sb.size()));
    chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    do_push = v && (sb.size() < DEPTH) && !fl && !rs;
    do_pop  = ordy && (sb.size() > 0) && !fl && !rs;
    if (do_pop) begin
      h = sb.pop_front();
      chk("group",   64'(out_dec.group),   64'(h.g));
      chk("ra",      64'(out_dec.ra),      64'(h.ra));
      chk("rb",      64'(out_dec.rb),      64'(h.rb));
      chk("rc",      64'(out_dec.rc),      64'(h.rc));
      chk("opcode",  64'(out_dec.opcode),  64'(h.op));
      chk("imm",     64'(out_dec.imm_val), 64'(h.imm));
      chk("invalid", 64'(out_invalid),     64'(h.inv));
      chk("pc",      64'(out_pc),          64'(h.pc));
    end
    @(posedge gclk);
    if (rs || fl) sb.delete();
    else if (do_push) sb.push_back(model(w, pc));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (3) @(posedge gclk);
    @(negedge gclk); reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_invalid", 64'(out_invalid), 64'd0);

    // Group 0, group 1, and an out-of-range group, each popped as it appears.
    cycle(1'b1, 32'h0123_4ABC, 32'h100, 1'b1);
    cycle(1'b1, 32'h1567_89AB, 32'h104, 1'b1);
    cycle(1'b1, 32'h7000_0000, 32'h108, 1'b1);
    cycle(1'b1, 32'h29AB_CDEF, 32'h10C, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Fill to DEPTH, then a pop-only cycle while in_valid is held.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h3000_0000 | (32'(i) << 12) | 32'h0011_0000, 32'h200 + 32'(4 * i), 1'b0);
    cycle(1'b1, 32'hFEED_0000, 32'h2FC, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("count_after_full_pop", 64'(count), 64'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Flush with two queued and a same-cycle push; the flushed word must not appear.
    cycle(1'b1, 32'h0A00_0001, 32'h300, 1'b0);
    cycle(1'b1, 32'h0B00_0002, 32'h304, 1'b0);
    cycle(1'b1, 32'h0C00_0003, 32'h308, 1'b0, 1'b1);
    cycle(1'b1, 32'h0D00_0004, 32'h30C, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Steady push+pop across pointer wrap with one entry in flight.
    cycle(1'b1, 32'h0000_0000, 32'h400, 1'b0);
    for (int i = 1; i <= 3 * DEPTH; i++)
      cycle(1'b1, {4'(i % 4), 4'(i), 4'(i + 1), 4'(i + 2), 16'(i * 16'h111)}, 32'h400 + 32'(4 * i), 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Reset mid-transfer with three queued.
    cycle(1'b1, 32'h8000_0000, 32'h500, 1'b0);
    cycle(1'b1, 32'h0111_1111, 32'h504, 1'b0);
    cycle(1'b1, 32'h1222_2222, 32'h508, 1'b0);
    cycle(1'b1, 32'h0333_3333, 32'h50C, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("post_rst_invalid", 64'(out_invalid), 64'd0);
    cycle(1'b1, 32'h0444_4444, 32'h600, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
